// File: rtl/addr8s_redundant_arb_if.sv
// Bundle between the time-redundant adder scheduler, its two requesters,
// the response consumer and the shared 8-bit signed adder.
interface addr8s_redundant_arb_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic       req1_valid;
    logic       req1_ready;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [8:0] rsp_sum;
    logic       rsp_err;
    logic [7:0] err_cnt;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [8:0] add_s;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready, add_s,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_err, err_cnt,
        input  add_a, add_b
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready, add_s,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_err, err_cnt,
        output add_a, add_b
    );
endinterface

// File: rtl/addr8s_redundant_arb.sv
// Round-robin, time-redundant scheduler for one shared 8-bit signed adder.
// Define ADDR8S_SWAP_CHECK_EN to recompute the second pass with swapped operands.
module addr8s_redundant_arb #(
    parameter int MAX_RETRY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    addr8s_redundant_arb_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN1  = 3'd1,
        S_RUN2  = 3'd2,
        S_CHECK = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] MAX_RETRY_C = 3'(MAX_RETRY);

    state_t     r_state;
    logic       r_last_id;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_id;
    logic [2:0] r_retry;
    logic [8:0] r_s1;
    logic [8:0] r_s2;
    logic       r_rsp_valid;
    logic       r_rsp_id;
    logic [8:0] r_rsp_sum;
    logic       r_rsp_err;
    logic [7:0] r_err_cnt;
    logic [7:0] r_add_a;
    logic [7:0] r_add_b;

    logic       w_grant_vld;
    logic       w_grant_id;
    logic       w_accept;
    logic [7:0] w_sel_a;
    logic [7:0] w_sel_b;
    logic [7:0] w_run2_a;
    logic [7:0] w_run2_b;

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = ~r_last_id;
        end else if (bus.req0_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b0;
        end else if (bus.req1_valid) begin
            w_grant_vld = 1'b1;
            w_grant_id  = 1'b1;
        end else begin
            w_grant_vld = 1'b0;
            w_grant_id  = 1'b0;
        end
    end

    assign w_accept       = (r_state == S_IDLE) && w_grant_vld && !rst;
    assign bus.req0_ready = w_accept && !w_grant_id;
    assign bus.req1_ready = w_accept && w_grant_id;
    assign w_sel_a        = w_grant_id ? bus.req1_a : bus.req0_a;
    assign w_sel_b        = w_grant_id ? bus.req1_b : bus.req0_b;

`ifdef ADDR8S_SWAP_CHECK_EN
    // Swapped second pass also exposes permanent faults that are operand-asymmetric.
    assign w_run2_a = r_b;
    assign w_run2_b = r_a;
`else
    assign w_run2_a = r_a;
    assign w_run2_b = r_b;
`endif

    // Scheduler FSM; adder operands are registered so the adder sees a full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_id   <= 1'b1;
            r_a         <= 8'd0;
            r_b         <= 8'd0;
            r_id        <= 1'b0;
            r_retry     <= 3'd0;
            r_s1        <= 9'd0;
            r_s2        <= 9'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_sum   <= 9'd0;
            r_rsp_err   <= 1'b0;
            r_err_cnt   <= 8'd0;
            r_add_a     <= 8'd0;
            r_add_b     <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_grant_id;
                        r_retry <= 3'd0;
                        r_add_a <= w_sel_a;
                        r_add_b <= w_sel_b;
                        r_state <= S_RUN1;
                    end else begin
                        r_add_a <= 8'd0;
                        r_add_b <= 8'd0;
                    end
                end
                S_RUN1: begin
                    r_s1    <= bus.add_s;
                    r_add_a <= w_run2_a;
                    r_add_b <= w_run2_b;
                    r_state <= S_RUN2;
                end
                S_RUN2: begin
                    r_s2    <= bus.add_s;
                    r_add_a <= 8'd0;
                    r_add_b <= 8'd0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (r_s1 == r_s2) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_rsp_sum   <= r_s1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        if (r_retry < MAX_RETRY_C) begin
                            r_retry <= r_retry + 3'd1;
                            r_add_a <= r_a;
                            r_add_b <= r_b;
                            r_state <= S_RUN1;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_id    <= r_id;
                            r_rsp_sum   <= r_s1;
                            r_rsp_err   <= 1'b1;
                            r_state     <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_last_id   <= r_rsp_id;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_add_a     <= 8'd0;
                    r_add_b     <= 8'd0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_sum   = r_rsp_sum;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.err_cnt   = r_err_cnt;
    assign bus.add_a     = r_add_a;
    assign bus.add_b     = r_add_b;
endmodule

// File: doc/addr8s_redundant_arb.md
# addr8s_redundant_arb

Time-redundant scheduler that shares one combinational 8-bit signed adder (9-bit sign-extended result) between two requesters. Each accepted request is evaluated twice on the shared adder and the two results are compared. A mismatch triggers a bounded retry. The block sits between client logic and an `addr8s_*` instance and adds transient-fault detection on top of the adder's structural fault resilience.

## Interface
- `MAX_RETRY`, default 2: re-evaluations allowed after a mismatch (1..7).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has operands.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_a`, `req0_b` in 8: signed operands, requester 0.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`: same for requester 1.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_id` out 1: requester the result belongs to.
- `rsp_sum` out 9: signed sum, two's complement, sign-extended.
- `rsp_err` out 1: unresolved mismatch after all retries.
- `err_cnt` out 8: saturating count of mismatches detected.
- `add_a`, `add_b` out 8: operands driven to the shared adder.
- `add_s` in 9: adder result, combinational from `add_a`/`add_b`.

## Operation
- States: IDLE, RUN1, RUN2, CHECK, RESP.
- IDLE:
  - Arbitration is round-robin. `last_id` resets to 1, so requester 0 wins first.
  - With both valid, the grant goes to `!last_id`. With one valid, that one is granted.
  - `reqN_ready` is high combinationally only for the granted requester in IDLE.
  - On handshake: latch operands and id, clear the retry counter, go to RUN1.
- RUN1: drive `add_a`=a, `add_b`=b. Register `add_s` into `s1` at the clock edge, then go to RUN2.
- RUN2: drive the second-pass operands (see Configuration). Register `add_s` into `s2`, then go to CHECK.
- CHECK:
  - `s1==s2`: go to RESP with `rsp_sum`=s1, `rsp_err`=0.
  - Mismatch: `err_cnt` increments, saturating at 255.
  - Mismatch with retry < MAX_RETRY: increment retry, go to RUN1.
  - Mismatch with retry = MAX_RETRY: go to RESP with `rsp_sum`=s1, `rsp_err`=1.
- RESP:
  - `rsp_valid`=1. `rsp_sum`, `rsp_id` and `rsp_err` are held stable until `rsp_ready`.
  - On handshake: `last_id`<=`rsp_id`, go to IDLE.
- `add_a`/`add_b` are 0 in IDLE, CHECK and RESP. This is a low-toggle idle for power.
- No new request is accepted while a result is pending; RESP must drain first.

## Timing
- Reset values:
  - State IDLE, `last_id`=1.
  - All outputs 0: `reqN_ready`, `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_err`, `err_cnt`, `add_a`, `add_b`.
- Reset asserted in any state aborts the transaction with no response. It also clears `err_cnt`.
- Latency, fault-free: handshake at edge k; `rsp_valid` high after edge k+4 (RUN1, RUN2, CHECK, RESP).
- Each retry adds 3 cycles. Worst case is 4+3·MAX_RETRY cycles.
- `rsp_valid` and `rsp_ready` in the same cycle complete the response. The next request can be accepted on the following cycle at the earliest; throughput is one request per 5 cycles.
- The adder path (about 35 ns) must fit in one clock period from the `add_a`/`add_b` registers to `s1`/`s2`.

## Configuration
- `ADDR8S_SWAP_CHECK_EN` defined: RUN2 drives `add_a`=b, `add_b`=a. Operand-swapped recomputation exposes asymmetric permanent faults as well as transients.
- Not defined: RUN2 drives the same a, b as RUN1. Only transient faults are detectable.

## Test plan
- req0 a=0x64 (100), b=0x1B (27), ideal adder:
  - `rsp_sum`=0x07F, `rsp_id`=0, `rsp_err`=0.
  - `rsp_valid` 4 cycles after handshake, `err_cnt`=0.
- req1 a=0x80 (-128), b=0xFF (-1) → `rsp_sum`=0x17F (-129), `rsp_err`=0.
- Both valid in consecutive IDLE windows, `rsp_ready`=1: grants alternate 0,1,0,1. A single continuously valid requester is granted every 5 cycles.
- Adder model flips `add_s[3]` only on its first evaluation, a=5, b=3:
  - One retry, `rsp_sum`=0x008, `rsp_err`=0.
  - Latency 7, `err_cnt`=1.
- With `ADDR8S_SWAP_CHECK_EN`: model corrupts bit 0 whenever `add_a`==0x05, a=5, b=3, MAX_RETRY=2:
  - Three mismatches, `rsp_err`=1, `err_cnt`=3, latency 10.
  - Without the macro, the same fault goes undetected (`rsp_err`=0, `err_cnt`=0).
- `rst` pulsed in RUN2, then `rsp_ready` held low:
  - No `rsp_valid`, all outputs 0, `last_id`=1.
  - Next request is accepted normally.
